// File: rtl/btn_debounce_multi.sv
// ============================================================================
// Module      : btn_debounce_multi
// Description : Multi-channel button debouncer with press/release/long-press
//               pulses and a registered debounced level per channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_multi #(
    parameter int NUM_CH            = 4,
    parameter int DEBOUNCE_CYCLES   = 255,
    parameter int LONG_PRESS_CYCLES = 65535,
    parameter bit ACTIVE_LOW        = 1'b0
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_pressed,
    output logic [NUM_CH-1:0] btn_released,
    output logic [NUM_CH-1:0] btn_long
);

    localparam int C_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int C_LC_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [C_DB_W-1:0] C_DB_LAST   = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_LC_W-1:0] C_LONG_LAST = C_LC_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [C_LC_W-1:0] C_LC_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

        state_t            state_q,      state_d;
        logic [C_DB_W-1:0] db_cnt_q,     db_cnt_d;
        logic [C_LC_W-1:0] long_cnt_q,   long_cnt_d;
        logic              long_fired_q, long_fired_d;
        logic              level_q,      level_d;
        logic              pressed_q,    pressed_d;
        logic              released_q,   released_d;
        logic              long_q,       long_d;
        logic              s;

        assign s = sync_q[1] ^ ACTIVE_LOW;

        always_comb begin
            state_d      = state_q;
            db_cnt_d     = db_cnt_q;
            long_cnt_d   = long_cnt_q;
            long_fired_d = long_fired_q;
            level_d      = level_q;
            pressed_d    = 1'b0;
            released_d   = 1'b0;
            long_d       = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_d  = ST_PRESS_WAIT;
                        db_cnt_d = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                    end else if (db_cnt_q == C_DB_LAST) begin
                        state_d      = ST_HELD;
                        level_d      = 1'b1;
                        pressed_d    = 1'b1;
                        long_cnt_d   = '0;
                        long_fired_d = 1'b0;
                    end else begin
                        db_cnt_d = db_cnt_q + C_DB_W'(1);
                    end
                end
                ST_HELD: begin
                    // Long counter measures time since the accepted press, so a
                    // rejected release glitch does not shift the long pulse.
                    if (long_cnt_q != C_LC_MAX) begin
                        long_cnt_d = long_cnt_q + C_LC_W'(1);
                    end
                    if (!s) begin
                        state_d  = ST_RELEASE_WAIT;
                        db_cnt_d = '0;
                    end else if ((long_cnt_q == C_LONG_LAST) && !long_fired_q) begin
                        long_d       = 1'b1;
                        long_fired_d = 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (long_cnt_q != C_LC_MAX) begin
                        long_cnt_d = long_cnt_q + C_LC_W'(1);
                    end
                    if (s) begin
                        state_d = ST_HELD;
                    end else if (db_cnt_q == C_DB_LAST) begin
                        state_d    = ST_IDLE;
                        level_d    = 1'b0;
                        released_d = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + C_DB_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge sysclk or posedge reset) begin
            if (reset) begin
                sync_q       <= '0;
                state_q      <= ST_IDLE;
                db_cnt_q     <= '0;
                long_cnt_q   <= '0;
                long_fired_q <= 1'b0;
                level_q      <= 1'b0;
                pressed_q    <= 1'b0;
                released_q   <= 1'b0;
                long_q       <= 1'b0;
            end else begin
                sync_q       <= {sync_q[0], btn[i]};
                state_q      <= state_d;
                db_cnt_q     <= db_cnt_d;
                long_cnt_q   <= long_cnt_d;
                long_fired_q <= long_fired_d;
                level_q      <= level_d;
                pressed_q    <= pressed_d;
                released_q   <= released_d;
                long_q       <= long_d;
            end
        end

        assign btn_level[i]    = level_q;
        assign btn_pressed[i]  = pressed_q;
        assign btn_released[i] = released_q;
        assign btn_long[i]     = long_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_multi.sv
// ============================================================================
// Module      : tb_btn_debounce_multi
// Description : Self-checking bench for btn_debounce_multi (scoreboard of
//               expected pulse events plus per-cycle level checks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce_multi;

    localparam int NUM_CH = 4;
    localparam int DB     = 8;
    localparam int LP     = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] btn = '0;
    logic [NUM_CH-1:0] btn_al = '1;
    logic [NUM_CH-1:0] btn_level, btn_pressed, btn_released, btn_long;
    logic [NUM_CH-1:0] al_level, al_pressed, al_released, al_long;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int               cyc;
        logic [NUM_CH-1:0] p;
        logic [NUM_CH-1:0] r;
        logic [NUM_CH-1:0] l;
    } ev_t;
    ev_t sb_q[$];

    btn_debounce_multi #(
        .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1'b0)
    ) dut (
        .sysclk(clk), .reset(reset), .btn(btn),
        .btn_level(btn_level), .btn_pressed(btn_pressed),
        .btn_released(btn_released), .btn_long(btn_long)
    );

    btn_debounce_multi #(
        .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .sysclk(clk), .reset(reset), .btn(btn_al),
        .btn_level(al_level), .btn_pressed(al_pressed),
        .btn_released(al_released), .btn_long(al_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic sb_push(input int cyc, input logic [NUM_CH-1:0] p,
                           input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] l);
        ev_t e;
        e.cyc = cyc; e.p = p; e.r = r; e.l = l;
        sb_q.push_back(e);
    endtask

    // Every pulse seen on the main DUT must match the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if ((btn_pressed | btn_released | btn_long) !== '0) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse edge=%0d actual p=%h r=%h l=%h required none",
                         edge_n, btn_pressed, btn_released, btn_long);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc !== edge_n || e.p !== btn_pressed || e.r !== btn_released || e.l !== btn_long) begin
                    errors++;
                    $display("FAIL pulse_event actual edge=%0d p=%h r=%h l=%h required edge=%0d p=%h r=%h l=%h",
                             edge_n, btn_pressed, btn_released, btn_long, e.cyc, e.p, e.r, e.l);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        btn   = '1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pressed, btn_released, btn_long,
                 al_level, al_pressed, al_released, al_long} !== '0) begin
                errors++;
                $display("FAIL reset_outputs actual=%h required=0",
                         {btn_level, btn_pressed, btn_released, btn_long,
                          al_level, al_pressed, al_released, al_long});
            end
        end
        btn = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL reset_sb_left actual=%0d required=0", sb_q.size());
        end
    endtask

    task automatic test_clean_press();
        int t0, k;
        @(negedge clk);
        btn[0] = 1'b1;
        t0 = edge_n + 1;
        sb_push(t0 + 10, 4'h1, 4'h0, 4'h0);
        sb_push(t0 + 30, 4'h0, 4'h1, 4'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k = edge_n - t0;
            btn[0] = (k + 1 < 20);
            checks++;
            if (btn_level[0] !== (k >= 10 && k < 30)) begin
                errors++;
                $display("FAIL clean_level k=%0d actual=%b required=%b", k, btn_level[0], (k >= 10 && k < 30));
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL clean_sb_left actual=%0d required=0", sb_q.size());
        end
    endtask

    task automatic test_bounce();
        int t0, k;
        @(negedge clk);
        btn[1] = 1'b1;
        t0 = edge_n + 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            k = edge_n - t0;
            btn[1] = (k + 1 < 40) && ((((k + 1) / 3) % 2) == 0);
            checks++;
            if (btn_level[1] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_level k=%0d actual=%b required=0", k, btn_level[1]);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_sb_left actual=%0d required=0", sb_q.size());
        end
    endtask

    task automatic test_long_press();
        int t0, k;
        @(negedge clk);
        btn[2] = 1'b1;
        t0 = edge_n + 1;
        sb_push(t0 + 10, 4'h4, 4'h0, 4'h0);
        sb_push(t0 + 42, 4'h0, 4'h0, 4'h4);
        sb_push(t0 + 70, 4'h0, 4'h4, 4'h0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            k = edge_n - t0;
            btn[2] = (k + 1 < 60);
            checks++;
            if (btn_level[2] !== (k >= 10 && k < 70)) begin
                errors++;
                $display("FAIL long_level k=%0d actual=%b required=%b", k, btn_level[2], (k >= 10 && k < 70));
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL long_sb_left actual=%0d required=0", sb_q.size());
        end
    endtask

    task automatic test_release_glitch();
        int t0, k, j;
        @(negedge clk);
        btn[0] = 1'b1;
        t0 = edge_n + 1;
        sb_push(t0 + 10, 4'h1, 4'h0, 4'h0);
        sb_push(t0 + 42, 4'h0, 4'h0, 4'h1);
        sb_push(t0 + 60, 4'h0, 4'h1, 4'h0);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            k = edge_n - t0;
            j = k + 1;
            btn[0] = (j < 50) && !(j >= 20 && j <= 22);
            checks++;
            if (btn_level[0] !== (k >= 10 && k < 60)) begin
                errors++;
                $display("FAIL glitch_level k=%0d actual=%b required=%b", k, btn_level[0], (k >= 10 && k < 60));
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_sb_left actual=%0d required=0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0, k;
        logic [NUM_CH-1:0] exp_lvl;
        @(negedge clk);
        btn = '1;
        t0 = edge_n + 1;
        sb_push(t0 + 10, 4'hF, 4'h0, 4'h0);
        sb_push(t0 + 25, 4'h0, 4'hF, 4'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            k = edge_n - t0;
            btn = (k + 1 < 15) ? '1 : '0;
            exp_lvl = (k >= 10 && k < 25) ? '1 : '0;
            checks++;
            if (btn_level !== exp_lvl) begin
                errors++;
                $display("FAIL multi_level k=%0d actual=%h required=%h", k, btn_level, exp_lvl);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL multi_sb_left actual=%0d required=0", sb_q.size());
        end
    endtask

    task automatic test_active_low();
        int t0, k;
        logic [NUM_CH-1:0] exp_p, exp_r;
        @(negedge clk);
        btn_al = '0;
        t0 = edge_n + 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            k = edge_n - t0;
            btn_al = (k + 1 < 15) ? '0 : '1;
            exp_p = (k == 10) ? '1 : '0;
            exp_r = (k == 25) ? '1 : '0;
            checks++;
            if (al_pressed !== exp_p) begin
                errors++;
                $display("FAIL al_pressed k=%0d actual=%h required=%h", k, al_pressed, exp_p);
            end
            checks++;
            if (al_released !== exp_r) begin
                errors++;
                $display("FAIL al_released k=%0d actual=%h required=%h", k, al_released, exp_r);
            end
            checks++;
            if (al_long !== '0) begin
                errors++;
                $display("FAIL al_long k=%0d actual=%h required=0", k, al_long);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, t1, t2;
        @(negedge clk);
        btn[0] = 1'b1;
        t0 = edge_n + 1;
        while (edge_n < t0 + 5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_pressed, btn_released, btn_long} !== '0) begin
            errors++;
            $display("FAIL rst_press_wait actual=%h required=0",
                     {btn_level, btn_pressed, btn_released, btn_long});
        end
        @(negedge clk);
        reset = 1'b0;
        t1 = edge_n + 1;
        sb_push(t1 + 10, 4'h1, 4'h0, 4'h0);
        while (edge_n < t1 + 20) @(negedge clk);
        checks++;
        if (btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_held_level actual=%b required=1", btn_level[0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_pressed, btn_released, btn_long} !== '0) begin
            errors++;
            $display("FAIL rst_held actual=%h required=0",
                     {btn_level, btn_pressed, btn_released, btn_long});
        end
        @(negedge clk);
        reset = 1'b0;
        t2 = edge_n + 1;
        sb_push(t2 + 10, 4'h1, 4'h0, 4'h0);
        while (edge_n < t2 + 14) @(negedge clk);
        btn[0] = 1'b0;
        sb_push(t2 + 25, 4'h0, 4'h1, 4'h0);
        while (edge_n < t2 + 35) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rst_sb_left actual=%0d required=0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_glitch();
        test_back_to_back();
        test_active_low();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
